// File: rtl/cell_comm_fa_packet_tx_if.sv
// rtl/cell_comm_fa_packet_tx_if.sv - 32-bit AXI-Stream TX bundle toward the Aurora core
interface cell_comm_fa_packet_tx_if;
   logic        axisTxTvalid;
   logic        axisTxTlast;
   logic [31:0] axisTxTdata;
   logic        axisTxTready;

   modport master (
      output axisTxTvalid,
      output axisTxTlast,
      output axisTxTdata,
      input  axisTxTready
   );

   modport slave (
      input  axisTxTvalid,
      input  axisTxTlast,
      input  axisTxTdata,
      output axisTxTready
   );
endinterface

// File: rtl/cell_comm_fa_packet_tx.sv
// rtl/cell_comm_fa_packet_tx.sv - FA sample snapshot and 5-word Aurora TX packet framer
module cell_comm_fa_packet_tx #(
   parameter logic [7:0]  MAGIC          = 8'hA5,
   parameter int unsigned TREADY_TIMEOUT = 1023
) (
   input  logic                     axisUserClk,
   input  logic                     axisUserReset,
   input  logic                     channelUp,
   input  logic [9:0]               cellIndex,
   input  logic [9:0]               bpmIndex,
   input  logic                     faStrobe,
   input  logic [31:0]              faX,
   input  logic [31:0]              faY,
   input  logic [31:0]              faS,
   cell_comm_fa_packet_tx_if.master axis_tx,
   output logic                     busy,
   output logic [31:0]              packetCount,
   output logic [31:0]              overrunCount,
   output logic [31:0]              abortCount
);
   localparam logic [15:0] TIMEOUT_W = 16'(TREADY_TIMEOUT);

   typedef enum logic [2:0] {ST_IDLE, ST_W0, ST_W1, ST_W2, ST_W3, ST_W4} state_t;

   state_t      state_q, state_d;
   logic        tvalid_q, tvalid_d;
   logic        tlast_q, tlast_d;
   logic [31:0] tdata_q, tdata_d;
   logic        busy_q, busy_d;
   logic [31:0] pkt_cnt_q, pkt_cnt_d;
   logic [31:0] ovr_cnt_q, ovr_cnt_d;
   logic [31:0] abt_cnt_q, abt_cnt_d;
   logic [15:0] seq_q, seq_d;
   logic [15:0] stall_q, stall_d;
   logic [31:0] snap_x_q, snap_x_d;
   logic [31:0] snap_y_q, snap_y_d;
   logic [31:0] snap_s_q, snap_s_d;
   // flags carried by the packet in flight vs. flags waiting for the next packet
   logic        snap_ovr_q, snap_ovr_d;
   logic        snap_abt_q, snap_abt_d;
   logic        pend_ovr_q, pend_ovr_d;
   logic        pend_abt_q, pend_abt_d;

   logic        handshake;
   logic        stalled;
   logic        abort;

   // next-state, output word and counter computation
   always_comb begin
      state_d    = state_q;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;
      tdata_d    = tdata_q;
      pkt_cnt_d  = pkt_cnt_q;
      ovr_cnt_d  = ovr_cnt_q;
      abt_cnt_d  = abt_cnt_q;
      seq_d      = seq_q;
      stall_d    = stall_q;
      snap_x_d   = snap_x_q;
      snap_y_d   = snap_y_q;
      snap_s_d   = snap_s_q;
      snap_ovr_d = snap_ovr_q;
      snap_abt_d = snap_abt_q;
      pend_ovr_d = pend_ovr_q;
      pend_abt_d = pend_abt_q;

      handshake = tvalid_q && axis_tx.axisTxTready;
      stalled   = tvalid_q && !axis_tx.axisTxTready;
      abort     = (state_q != ST_IDLE) &&
                  (!channelUp || (stalled && ((stall_q + 16'd1) == TIMEOUT_W)));

      // any strobe while a packet is being built is dropped, including the W4 cycle
      if ((state_q != ST_IDLE) && faStrobe) begin
         ovr_cnt_d  = ovr_cnt_q + 32'd1;
         pend_ovr_d = 1'b1;
      end

      if (state_q == ST_IDLE) begin
         stall_d = '0;
         if (faStrobe && channelUp) begin
            // W0 is built here from the indices, so tdata_q acts as their snapshot
            snap_x_d   = faX;
            snap_y_d   = faY;
            snap_s_d   = faS;
            snap_ovr_d = pend_ovr_q;
            snap_abt_d = pend_abt_q;
            pend_ovr_d = 1'b0;
            pend_abt_d = 1'b0;
            state_d    = ST_W0;
            tvalid_d   = 1'b1;
            tlast_d    = 1'b0;
            tdata_d    = {MAGIC, cellIndex, 4'b0000, bpmIndex};
         end
      end else if (abort) begin
         // an aborted packet never delivered its flags, so hand them back to the next one
         state_d    = ST_IDLE;
         tvalid_d   = 1'b0;
         tlast_d    = 1'b0;
         tdata_d    = '0;
         stall_d    = '0;
         abt_cnt_d  = abt_cnt_q + 32'd1;
         pend_abt_d = 1'b1;
         pend_ovr_d = pend_ovr_d | snap_ovr_q;
         snap_ovr_d = 1'b0;
         snap_abt_d = 1'b0;
      end else if (handshake) begin
         stall_d = '0;
         case (state_q)
            ST_W0: begin
               state_d = ST_W1;
               tdata_d = {seq_q, 14'b0, snap_ovr_q, snap_abt_q};
            end
            ST_W1: begin
               state_d = ST_W2;
               tdata_d = snap_x_q;
            end
            ST_W2: begin
               state_d = ST_W3;
               tdata_d = snap_y_q;
            end
            ST_W3: begin
               state_d = ST_W4;
               tdata_d = snap_s_q;
               tlast_d = 1'b1;
            end
            default: begin
               state_d    = ST_IDLE;
               tvalid_d   = 1'b0;
               tlast_d    = 1'b0;
               tdata_d    = '0;
               pkt_cnt_d  = pkt_cnt_q + 32'd1;
               seq_d      = seq_q + 16'd1;
               snap_ovr_d = 1'b0;
               snap_abt_d = 1'b0;
            end
         endcase
      end else if (stalled) begin
         stall_d = stall_q + 16'd1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // state and registered outputs, cleared immediately by the link reset
   always_ff @(posedge axisUserClk or posedge axisUserReset) begin
      if (axisUserReset) begin
         state_q    <= ST_IDLE;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tdata_q    <= '0;
         busy_q     <= 1'b0;
         pkt_cnt_q  <= '0;
         ovr_cnt_q  <= '0;
         abt_cnt_q  <= '0;
         seq_q      <= '0;
         stall_q    <= '0;
         snap_x_q   <= '0;
         snap_y_q   <= '0;
         snap_s_q   <= '0;
         snap_ovr_q <= 1'b0;
         snap_abt_q <= 1'b0;
         pend_ovr_q <= 1'b0;
         pend_abt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tdata_q    <= tdata_d;
         busy_q     <= busy_d;
         pkt_cnt_q  <= pkt_cnt_d;
         ovr_cnt_q  <= ovr_cnt_d;
         abt_cnt_q  <= abt_cnt_d;
         seq_q      <= seq_d;
         stall_q    <= stall_d;
         snap_x_q   <= snap_x_d;
         snap_y_q   <= snap_y_d;
         snap_s_q   <= snap_s_d;
         snap_ovr_q <= snap_ovr_d;
         snap_abt_q <= snap_abt_d;
         pend_ovr_q <= pend_ovr_d;
         pend_abt_q <= pend_abt_d;
      end
   end

   assign axis_tx.axisTxTvalid = tvalid_q;
   assign axis_tx.axisTxTlast  = tlast_q;
   assign axis_tx.axisTxTdata  = tdata_q;
   assign busy                 = busy_q;
   assign packetCount          = pkt_cnt_q;
   assign overrunCount         = ovr_cnt_q;
   assign abortCount           = abt_cnt_q;
endmodule
